// File: rtl/modport_pkg.sv
// modport_pkg
//   Shared constants and helpers for the windowed accumulator slice.
//   DEF_WIDTH  : default data word width.
//   DEF_WINDOW : default number of valid words summed per result.
//   cnt_width(): width of the in-window sample counter (never below 1 bit).
package modport_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_WINDOW = 4;

  function automatic int cnt_width(input int window);
    int w;
    w = $clog2(window);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/modport_dut_sat_adder.sv
// sat_adder
//   Combinational unsigned saturating adder.
//   a, b : WIDTH-bit unsigned operands.
//   sum  : a+b, clamped to all-ones when the addition carries out.
module sat_adder #(
  parameter int WIDTH = modport_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign sum  = full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];

endmodule

// File: rtl/modport_dut.sv
// modport_dut
//   Streaming windowed accumulator. Every WINDOW valid input words are summed
//   with unsigned saturation and emitted as one registered result with a
//   single-cycle valid pulse. No backpressure.
//   CLK       : clock, rising edge.
//   RESET     : asynchronous active-high reset; discards any partial window.
//   IN_VALUE  : input word, only looked at while IN_VALID=1.
//   IN_VALID  : input qualifier.
//   OUT_VALUE : last window result (held between pulses).
//   OUT_VALID : one-cycle pulse per new OUT_VALUE.
module modport_dut
  import modport_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN_VALUE,
  input  logic             IN_VALID,
  output logic [WIDTH-1:0] OUT_VALUE,
  output logic             OUT_VALID
);

  localparam int CW = cnt_width(WINDOW);
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_sum;
  logic             win_done;

  sat_adder #(.WIDTH(WIDTH)) u_sat_adder (
    .a   (acc),
    .b   (IN_VALUE),
    .sum (acc_sum)
  );

  assign win_done = (cnt == LAST);

  // Everything is gated by IN_VALID so X on IN_VALUE during idle cycles
  // never reaches a flop. OUT_VALID clears on every edge that does not
  // complete a window, giving exactly one cycle per result.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt       <= '0;
      acc       <= '0;
      OUT_VALUE <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      if (IN_VALID) begin
        if (win_done) begin
          OUT_VALUE <= acc_sum;
          OUT_VALID <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_modport_dut.sv
module tb_modport_dut;

  logic        clk;
  logic        rst;
  logic [31:0] in_a;
  logic        vld_a;
  logic [31:0] out_a;
  logic        ovld_a;
  logic [7:0]  in_b;
  logic        vld_b;
  logic [7:0]  out_b;
  logic        ovld_b;

  int checks;
  int failures;

  modport_dut #(.WIDTH(32), .WINDOW(4)) u_dut_a (
    .CLK       (clk),
    .RESET     (rst),
    .IN_VALUE  (in_a),
    .IN_VALID  (vld_a),
    .OUT_VALUE (out_a),
    .OUT_VALID (ovld_a)
  );

  modport_dut #(.WIDTH(8), .WINDOW(1)) u_dut_b (
    .CLK       (clk),
    .RESET     (rst),
    .IN_VALUE  (in_b),
    .IN_VALID  (vld_b),
    .OUT_VALUE (out_b),
    .OUT_VALID (ovld_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven and
  // outputs of the edge just taken are sampled from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    in_a  = '0;
    vld_a = 1'b0;
    in_b  = '0;
    vld_b = 1'b0;
    #3;
    checks++;
    if (out_a !== 32'd0 || ovld_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_a got value=%0h valid=%0b want 0/0", out_a, ovld_a);
    end
    checks++;
    if (out_b !== 8'd0 || ovld_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_b got value=%0h valid=%0b want 0/0", out_b, ovld_b);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] words [4];
    words = '{32'd1, 32'd2, 32'd3, 32'd4};
    for (int i = 0; i < 4; i++) begin
      in_a = words[i]; vld_a = 1'b1;
      tick();
      checks++;
      if (ovld_a !== (i == 3)) begin
        failures++;
        $display("FAIL basic_valid word=%0d got=%0b want=%0b", i, ovld_a, (i == 3));
      end
    end
    checks++;
    if (out_a !== 32'd10) begin
      failures++;
      $display("FAIL basic_value got=%0d want=10", out_a);
    end
    vld_a = 1'b0; in_a = 'x;
    tick();
    checks++;
    if (ovld_a !== 1'b0 || out_a !== 32'd10) begin
      failures++;
      $display("FAIL basic_hold got value=%0d valid=%0b want 10/0", out_a, ovld_a);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] words [4];
    int gaps [4];
    words = '{32'd5, 32'd6, 32'd7, 32'd8};
    gaps  = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        vld_a = 1'b0; in_a = 'x;
        tick();
        checks++;
        if (ovld_a !== 1'b0) begin
          failures++;
          $display("FAIL gaps_idle word=%0d gap=%0d got valid=%0b want 0", i, g, ovld_a);
        end
      end
      in_a = words[i]; vld_a = 1'b1;
      tick();
      checks++;
      if (ovld_a !== (i == 3)) begin
        failures++;
        $display("FAIL gaps_valid word=%0d got=%0b want=%0b", i, ovld_a, (i == 3));
      end
    end
    checks++;
    if (out_a !== 32'd26) begin
      failures++;
      $display("FAIL gaps_value got=%0d want=26", out_a);
    end
    vld_a = 1'b0; in_a = 'x;
    tick();
  endtask

  task automatic test_saturation();
    logic [31:0] words [8];
    words = '{32'hFFFF_FFF0, 32'h20, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    for (int i = 0; i < 8; i++) begin
      in_a = words[i]; vld_a = 1'b1;
      tick();
      if (i == 3) begin
        checks++;
        if (ovld_a !== 1'b1 || out_a !== 32'hFFFF_FFFF) begin
          failures++;
          $display("FAIL sat_clamp got value=%0h valid=%0b want ffffffff/1", out_a, ovld_a);
        end
      end
      if (i == 7) begin
        checks++;
        if (ovld_a !== 1'b1 || out_a !== 32'd4) begin
          failures++;
          $display("FAIL sat_next_window got value=%0h valid=%0b want 4/1", out_a, ovld_a);
        end
      end
    end
    vld_a = 1'b0; in_a = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] sums [3];
    int n;
    sums = '{32'd10, 32'd26, 32'd42};
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      in_a = 32'(k); vld_a = 1'b1;
      tick();
      checks++;
      if ((k % 4) == 0) begin
        if (ovld_a !== 1'b1 || out_a !== sums[n]) begin
          failures++;
          $display("FAIL b2b_pulse k=%0d got value=%0d valid=%0b want %0d/1", k, out_a, ovld_a, sums[n]);
        end
        n++;
      end else if (ovld_a !== 1'b0) begin
        failures++;
        $display("FAIL b2b_quiet k=%0d got valid=%0b want 0", k, ovld_a);
      end
    end
    vld_a = 1'b0; in_a = '0;
    tick();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      in_a = 32'd1; vld_a = 1'b1;
      tick();
    end
    vld_a = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_a !== 32'd0 || ovld_a !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got value=%0h valid=%0b want 0/0", out_a, ovld_a);
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_a = 32'd1; vld_a = 1'b1;
      tick();
      checks++;
      if (ovld_a !== (i == 3)) begin
        failures++;
        $display("FAIL async_after_valid word=%0d got=%0b want=%0b", i, ovld_a, (i == 3));
      end
    end
    checks++;
    if (out_a !== 32'd4) begin
      failures++;
      $display("FAIL async_after_value got=%0d want=4", out_a);
    end
    vld_a = 1'b0; in_a = '0;
    tick();
  endtask

  task automatic test_window1();
    logic [7:0] words [3];
    words = '{8'd3, 8'd200, 8'd0};
    for (int i = 0; i < 3; i++) begin
      in_b = words[i]; vld_b = 1'b1;
      tick();
      checks++;
      if (ovld_b !== 1'b1 || out_b !== words[i]) begin
        failures++;
        $display("FAIL win1_stream i=%0d got value=%0d valid=%0b want %0d/1", i, out_b, ovld_b, words[i]);
      end
    end
    vld_b = 1'b0; in_b = 'x;
    tick();
    checks++;
    if (ovld_b !== 1'b0) begin
      failures++;
      $display("FAIL win1_drop got valid=%0b want 0", ovld_b);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_saturation();
    test_back_to_back();
    test_async_reset();
    test_window1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
